// File: rtl/egress_pkg.sv
// Shared definitions for the egress byte framer: FSM state codes, default
// framing bytes and the CRC-8 (poly 0x07, MSB first) byte update.
package egress_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SYNC_A  = 3'd1;
    localparam state_t ST_SYNC_B  = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_CRC     = 3'd4;

    localparam logic [7:0] DEF_SYNC_A    = 8'hF6;
    localparam logic [7:0] DEF_SYNC_B    = 8'h28;
    localparam logic [7:0] DEF_IDLE_BYTE = 8'h00;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    // Fold one byte into a non-reflected CRC-8, most significant bit first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/egress_byte_framer_word_fifo.sv
// Small synchronous word FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable; a push into a full FIFO is accepted only when a
// pop happens on the same edge (the freed slot is the one being written).
module word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/egress_byte_framer.sv
// Egress byte framer: captures one 64-bit word per rising edge of valid_in,
// buffers it in a small FIFO and emits frames SYNC_A, SYNC_B, 8 payload bytes
// (MSB first). Back-to-back frames are emitted without an idle gap.
// Optional feature macro: EGRESS_CRC_EN appends a CRC-8 byte to each frame.
module egress_byte_framer
    import egress_pkg::*;
#(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [7:0] SYNC_A     = DEF_SYNC_A,
    parameter logic [7:0] SYNC_B     = DEF_SYNC_B,
    parameter logic [7:0] IDLE_BYTE  = DEF_IDLE_BYTE,
    parameter int         CNT_W      = 16
) (
    input  logic             clk_div_8,
    input  logic             reset_n,
    input  logic [63:0]      data_in,
    input  logic             valid_in,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             frame_start,
    output logic             ovf_pulse,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    logic             valid_d_r;
    logic             capture_s;
    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic             eof_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [63:0]      fifo_data_s;

    state_t           state_r;
    state_t           state_nx;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nx;
    logic [63:0]      shreg_r;
    logic [63:0]      shreg_nx;
    logic [7:0]       byte_nx;
    logic             bvalid_nx;
    logic             fs_nx;

    logic [7:0]       byte_out_r;
    logic             byte_valid_r;
    logic             frame_start_r;
    logic             ovf_pulse_r;
    logic [CNT_W-1:0] pkt_count_r;
    logic [CNT_W-1:0] drop_count_r;

`ifdef EGRESS_CRC_EN
    logic [7:0]       crc_r;
    logic [7:0]       crc_nx;
`endif

    // Only the rising edge of the valid level captures; a full FIFO still
    // accepts the word when a pop frees a slot on the same edge.
    assign capture_s = valid_in & ~valid_d_r;
    assign push_s    = capture_s & (~fifo_full_s | pop_s);
    assign drop_s    = capture_s & fifo_full_s & ~pop_s;

    word_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_div_8),
        .rst_n     (reset_n),
        .push      (push_s),
        .push_data (data_in),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next-state and next-output decode; outputs are computed one edge early
    // so the registered byte lines up with the state being entered.
    always_comb begin
        state_nx  = state_r;
        idx_nx    = idx_r;
        shreg_nx  = shreg_r;
        byte_nx   = IDLE_BYTE;
        bvalid_nx = 1'b0;
        fs_nx     = 1'b0;
        eof_s     = 1'b0;
`ifdef EGRESS_CRC_EN
        crc_nx    = crc_r;
`endif
        case (state_r)
            ST_IDLE: begin
                state_nx = ST_IDLE;
            end
            ST_SYNC_A: begin
                state_nx  = ST_SYNC_B;
                byte_nx   = SYNC_B;
                bvalid_nx = 1'b1;
            end
            ST_SYNC_B: begin
                state_nx  = ST_PAYLOAD;
                idx_nx    = 3'd0;
                byte_nx   = shreg_r[63:56];
                bvalid_nx = 1'b1;
                shreg_nx  = {shreg_r[55:0], 8'h00};
`ifdef EGRESS_CRC_EN
                crc_nx    = crc8_byte(crc_r, shreg_r[63:56]);
`endif
            end
            ST_PAYLOAD: begin
                if (idx_r != 3'd7) begin
                    idx_nx    = idx_r + 3'd1;
                    byte_nx   = shreg_r[63:56];
                    bvalid_nx = 1'b1;
                    shreg_nx  = {shreg_r[55:0], 8'h00};
`ifdef EGRESS_CRC_EN
                    crc_nx    = crc8_byte(crc_r, shreg_r[63:56]);
`endif
                end else begin
`ifdef EGRESS_CRC_EN
                    state_nx  = ST_CRC;
                    byte_nx   = crc_r;
                    bvalid_nx = 1'b1;
`else
                    state_nx  = ST_IDLE;
                    eof_s     = 1'b1;
`endif
                end
            end
`ifdef EGRESS_CRC_EN
            ST_CRC: begin
                state_nx = ST_IDLE;
                eof_s    = 1'b1;
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Start a frame from idle, or chain directly after the last byte.
        pop_s = ~fifo_empty_s & ((state_r == ST_IDLE) | eof_s);
        if (pop_s) begin
            state_nx  = ST_SYNC_A;
            shreg_nx  = fifo_data_s;
            byte_nx   = SYNC_A;
            bvalid_nx = 1'b1;
            fs_nx     = 1'b1;
`ifdef EGRESS_CRC_EN
            crc_nx    = 8'h00;
`endif
        end else begin
            fs_nx = 1'b0;
        end
    end

    // Edge-detect register for valid_in.
    always_ff @(posedge clk_div_8 or negedge reset_n) begin
        if (!reset_n) begin
            valid_d_r <= 1'b0;
        end else begin
            valid_d_r <= valid_in;
        end
    end

    // FSM, shift register and registered stream outputs.
    always_ff @(posedge clk_div_8 or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= 3'd0;
            shreg_r       <= 64'h0;
            byte_out_r    <= IDLE_BYTE;
            byte_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_nx;
            idx_r         <= idx_nx;
            shreg_r       <= shreg_nx;
            byte_out_r    <= byte_nx;
            byte_valid_r  <= bvalid_nx;
            frame_start_r <= fs_nx;
        end
    end

`ifdef EGRESS_CRC_EN
    // Running CRC over the payload bytes already emitted.
    always_ff @(posedge clk_div_8 or negedge reset_n) begin
        if (!reset_n) begin
            crc_r <= 8'h00;
        end else begin
            crc_r <= crc_nx;
        end
    end
`endif

    // Status: wrapping frame counter, saturating drop counter, overflow pulse.
    always_ff @(posedge clk_div_8 or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count_r  <= {CNT_W{1'b0}};
            drop_count_r <= {CNT_W{1'b0}};
            ovf_pulse_r  <= 1'b0;
        end else begin
            ovf_pulse_r <= drop_s;
            if (eof_s) begin
                pkt_count_r <= pkt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (drop_s && (drop_count_r != {CNT_W{1'b1}})) begin
                drop_count_r <= drop_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign byte_out    = byte_out_r;
    assign byte_valid  = byte_valid_r;
    assign frame_start = frame_start_r;
    assign ovf_pulse   = ovf_pulse_r;
    assign pkt_count   = pkt_count_r;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_egress_byte_framer.sv
// Self-checking bench for egress_byte_framer: expected frame bytes are queued
// when a capture is driven and compared as the stream appears.
module tb_egress_byte_framer;

    typedef struct {
        logic [7:0] b;
        logic       fs;
    } exp_t;

`ifdef EGRESS_CRC_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif

    logic        clk_div_8 = 1'b0;
    logic        reset_n   = 1'b0;
    logic [63:0] data_in   = 64'h0;
    logic        valid_in  = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_start;
    logic        ovf_pulse;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   frames_seen = 0;
    int   ovf_seen = 0;
    int   cur_run = 0;
    int   max_run = 0;

    egress_byte_framer #(.FIFO_DEPTH(2)) dut (
        .clk_div_8   (clk_div_8),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .ovf_pulse   (ovf_pulse),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count)
    );

    always #5 clk_div_8 = ~clk_div_8;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] ref_crc(input logic [63:0] w);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 63; i >= 0; i--) begin
            fb = c[7] ^ w[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic void push_byte(input logic [7:0] b, input logic fs);
        exp_t e;
        e.b  = b;
        e.fs = fs;
        sb.push_back(e);
    endfunction

    function automatic void push_frame(input logic [63:0] w);
        push_byte(8'hF6, 1'b1);
        push_byte(8'h28, 1'b0);
        for (int i = 7; i >= 0; i--) push_byte(w[i*8 +: 8], 1'b0);
`ifdef EGRESS_CRC_EN
        push_byte(ref_crc(w), 1'b0);
`endif
    endfunction

    // Stream monitor: compares every sampled cycle against the scoreboard.
    always @(negedge clk_div_8) begin
        if (reset_n === 1'b1) begin
            if (ovf_pulse === 1'b1) ovf_seen++;
            if (frame_start === 1'b1) frames_seen++;
            if (byte_valid === 1'b1) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got byte %02h fs=%b, expected no byte", byte_out, frame_start);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (byte_out !== e.b || frame_start !== e.fs) begin
                        n_bad++;
                        $display("FAIL stream_byte: got %02h fs=%b, expected %02h fs=%b",
                                 byte_out, frame_start, e.b, e.fs);
                    end
                end
            end else begin
                cur_run = 0;
                n_cmp++;
                if (byte_out !== 8'h00 || frame_start !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_byte: got %02h fs=%b, expected 00 fs=0", byte_out, frame_start);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_div_8);
        #1;
    endtask

    task automatic clear_stats();
        sb.delete();
        frames_seen = 0;
        ovf_seen    = 0;
        cur_run     = 0;
        max_run     = 0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        valid_in = 1'b0;
        clear_stats();
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_div_8);
            if (sb.size() == 0 && byte_valid === 1'b0) break;
        end
        tick(1);
    endtask

    task automatic capture_pulse(input logic [63:0] w, input bit expect_out);
        data_in  = w;
        valid_in = 1'b1;
        if (expect_out) push_frame(w);
        tick(1);
        valid_in = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (byte_out !== 8'h00) begin n_bad++; $display("FAIL rst_byte_out: got %02h expected 00", byte_out); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL rst_byte_valid: got %b expected 0", byte_valid); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start: got %b expected 0", frame_start); end
        n_cmp++; if (ovf_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b expected 0", ovf_pulse); end
        n_cmp++; if (pkt_count !== 16'd0) begin n_bad++; $display("FAIL rst_pkt: got %0d expected 0", pkt_count); end
        n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL rst_drop: got %0d expected 0", drop_count); end
    endtask

    task automatic test_single();
        do_reset();
        data_in  = 64'h0102030405060708;
        valid_in = 1'b1;
        push_frame(data_in);
        tick(26);
        valid_in = 1'b0;
        drain(100);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL single_left: %0d bytes missing, expected 0", sb.size()); end
        n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL single_pkt: got %0d expected 1", pkt_count); end
        n_cmp++; if (frames_seen != 1) begin n_bad++; $display("FAIL single_fs: got %0d pulses expected 1", frames_seen); end
        n_cmp++; if (max_run != FLEN) begin n_bad++; $display("FAIL single_len: got %0d expected %0d", max_run, FLEN); end
    endtask

    task automatic test_held();
        reset_n = 1'b0;
        clear_stats();
        data_in  = 64'hDEADBEEFCAFE1234;
        valid_in = 1'b1;
        tick(2);
        reset_n = 1'b1;
        push_frame(data_in);
        tick(100);
        valid_in = 1'b0;
        drain(100);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL held_left: %0d bytes missing, expected 0", sb.size()); end
        n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL held_pkt: got %0d expected 1", pkt_count); end
        n_cmp++; if (frames_seen != 1) begin n_bad++; $display("FAIL held_fs: got %0d expected 1", frames_seen); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        capture_pulse(64'h1111111111111111, 1'b1);
        capture_pulse(64'hA5A5A5A55A5A5A5A, 1'b1);
        capture_pulse(64'h0F1E2D3C4B5A6978, 1'b1);
        drain(100);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_left: %0d bytes missing, expected 0", sb.size()); end
        n_cmp++; if (pkt_count !== 16'd3) begin n_bad++; $display("FAIL b2b_pkt: got %0d expected 3", pkt_count); end
        n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL b2b_drop: got %0d expected 0", drop_count); end
        n_cmp++; if (max_run != 3 * FLEN) begin n_bad++; $display("FAIL b2b_run: got %0d expected %0d", max_run, 3 * FLEN); end
    endtask

    task automatic test_overflow();
        do_reset();
        capture_pulse(64'h8877665544332211, 1'b1);
        capture_pulse(64'h0123456789ABCDEF, 1'b1);
        capture_pulse(64'hFEDCBA9876543210, 1'b1);
        capture_pulse(64'hFFFFFFFFFFFFFFFF, 1'b0);
        drain(100);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL ovf_left: %0d bytes missing, expected 0", sb.size()); end
        n_cmp++; if (drop_count !== 16'd1) begin n_bad++; $display("FAIL ovf_drop: got %0d expected 1", drop_count); end
        n_cmp++; if (ovf_seen != 1) begin n_bad++; $display("FAIL ovf_pulse: got %0d pulses expected 1", ovf_seen); end
        n_cmp++; if (pkt_count !== 16'd3) begin n_bad++; $display("FAIL ovf_pkt: got %0d expected 3", pkt_count); end
        n_cmp++; if (frames_seen != 3) begin n_bad++; $display("FAIL ovf_frames: got %0d expected 3", frames_seen); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        data_in  = 64'h0102030405060708;
        valid_in = 1'b1;
        push_frame(data_in);
        tick(1);
        valid_in = 1'b0;
        tick(7);
        n_cmp++; if (byte_out !== 8'h05 || byte_valid !== 1'b1) begin
            n_bad++; $display("FAIL mid_byte4: got %02h v=%b expected 05 v=1", byte_out, byte_valid);
        end
        #2;
        reset_n = 1'b0;
        clear_stats();
        #1;
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", byte_valid); end
        n_cmp++; if (byte_out !== 8'h00) begin n_bad++; $display("FAIL mid_rst_byte: got %02h expected 00", byte_out); end
        n_cmp++; if (pkt_count !== 16'd0 || drop_count !== 16'd0) begin
            n_bad++; $display("FAIL mid_rst_cnt: got pkt %0d drop %0d expected 0 0", pkt_count, drop_count);
        end
        tick(2);
        reset_n = 1'b1;
        tick(3);
        n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_resume: got v=%b expected 0", byte_valid); end
        capture_pulse(64'hC0FFEE0012345678, 1'b1);
        drain(100);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL mid_left: %0d bytes missing, expected 0", sb.size()); end
        n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL mid_pkt: got %0d expected 1", pkt_count); end
        n_cmp++; if (max_run != FLEN) begin n_bad++; $display("FAIL mid_len: got %0d expected %0d", max_run, FLEN); end
    endtask

`ifdef EGRESS_CRC_EN
    task automatic test_crc();
        do_reset();
        data_in  = 64'h0000000000000001;
        valid_in = 1'b1;
        push_byte(8'hF6, 1'b1);
        push_byte(8'h28, 1'b0);
        for (int i = 0; i < 7; i++) push_byte(8'h00, 1'b0);
        push_byte(8'h01, 1'b0);
        push_byte(8'h07, 1'b0);
        tick(1);
        valid_in = 1'b0;
        drain(100);
        n_cmp++; if (max_run != 11) begin n_bad++; $display("FAIL crc_len: got %0d expected 11", max_run); end
        data_in  = 64'h0;
        valid_in = 1'b1;
        push_byte(8'hF6, 1'b1);
        push_byte(8'h28, 1'b0);
        for (int i = 0; i < 9; i++) push_byte(8'h00, 1'b0);
        tick(1);
        valid_in = 1'b0;
        drain(100);
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL crc_left: %0d bytes missing, expected 0", sb.size()); end
        n_cmp++; if (pkt_count !== 16'd2) begin n_bad++; $display("FAIL crc_pkt: got %0d expected 2", pkt_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_held();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef EGRESS_CRC_EN
        test_crc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/egress_byte_framer.md
# egress_byte_framer

Downstream stage of the queue controller: captures each 64-bit dequeued packet word presented on `data_out`/`valid_data_out` and re-serialises it into a framed byte stream on `clk_div_8`. Each frame is two sync bytes (A, B) followed by the 8 payload bytes, MSB first. A small word FIFO absorbs back-to-back dequeues. Packet and drop counters are exported for status.

## Interface
- `FIFO_DEPTH`, 2: word FIFO entries (power of two, ≥2).
- `SYNC_A`, 8'hF6: first sync byte.
- `SYNC_B`, 8'h28: second sync byte.
- `IDLE_BYTE`, 8'h00: byte driven when no frame is in progress.
- `CNT_W`, 16: width of the status counters.

Ports:
- `clk_div_8`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  64  packet word from the queue controller `data_out`.
- `valid_in`  in  1  the queue controller `valid_data_out`; a level held for many cycles per word.
- `byte_out`  out  8  framed byte stream.
- `byte_valid`  out  1  high while `byte_out` carries a frame byte.
- `frame_start`  out  1  single-cycle pulse coincident with the `SYNC_A` byte.
- `ovf_pulse`  out  1  single-cycle pulse when a word is dropped because the FIFO is full.
- `pkt_count`  out  CNT_W  frames completed; wraps.
- `drop_count`  out  CNT_W  words dropped; saturates at all-ones.

## Operation
- Capture: a registered `valid_d` detects the rising edge of `valid_in`. On `valid_in & ~valid_d`, `data_in` is pushed into the FIFO. Only one word is taken per high level, however long the level lasts.
- FSM states: IDLE, SYNC_A, SYNC_B, PAYLOAD (3-bit index 0..7), CRC (only with the macro).
- IDLE & FIFO non-empty: pop the word into a 64-bit shift register and go to SYNC_A. Otherwise stay in IDLE.
- SYNC_A → SYNC_B → PAYLOAD.
- PAYLOAD emits `word[63:56]` first, then shifts left 8 bits per cycle. After index 7 the FSM moves to CRC (macro on) or ends the frame (macro off).
- End of frame:
  - `pkt_count` +1.
  - If the FIFO is non-empty, pop the next word and enter SYNC_A directly, with no idle gap.
  - Otherwise return to IDLE.
- FIFO full on a capture with no pop in the same cycle: discard the word, pulse `ovf_pulse`, and increment `drop_count` (saturating).
- FIFO full on a capture with a pop in the same cycle: the push is accepted.
- Empty FIFO with a capture: the word is never bypassed; it is popped on the following edge.
- Outputs are registered. In IDLE: `byte_out`=`IDLE_BYTE`, `byte_valid`=0.

## Timing
- Reset values: `byte_out`=`IDLE_BYTE`, `byte_valid`=0, `frame_start`=0, `ovf_pulse`=0, `pkt_count`=0, `drop_count`=0. Also FIFO empty, FSM IDLE, `valid_d`=0.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronous), FIFO contents are lost, and no partial frame resumes.
- Because `valid_d` resets to 0, `valid_in` already high at the first edge after reset release counts as a rising edge and is captured.
- Latency: capture at edge t0 (FIFO previously empty, FSM IDLE) → pop at t1 → `SYNC_A` visible after t1. Then `SYNC_B` after t2 and payload bytes after t3..t10 (CRC after t11).
- Frame length is 10 cycles (11 with CRC). `byte_valid` stays high continuously across back-to-back frames.
- The queue controller presents one word per ≥26 cycles. `FIFO_DEPTH`=2 therefore never overflows in normal operation; overflow handling covers misbehaving upstream logic only.

## Configuration
- `EGRESS_CRC_EN` defined: the CRC state appends a CRC-8 byte after the payload.
  - Polynomial 0x07, init 0x00, non-reflected, no final XOR.
  - Computed over the 8 payload bytes in transmit order, updated during PAYLOAD.
  - The frame is 11 bytes.
- `EGRESS_CRC_EN` undefined: no CRC state or logic; the frame is 10 bytes.

## Structure
- Package `egress_pkg` holds:
  - the FSM state enum;
  - default `SYNC_A`/`SYNC_B`/`IDLE_BYTE` constants;
  - the `CRC8_POLY` constant;
  - a `crc8_byte(crc, byte)` function.
- One sub-module `word_fifo`: parameterised width/depth synchronous FIFO with push, pop, full, empty, and simultaneous push/pop support.
- The FSM, edge detect and counters live in the top module.

## Test plan
- Single word: `valid_in` high for 26 cycles with `data_in`=64'h0102030405060708 → exactly one frame F6 28 01 02 03 04 05 06 07 08. `frame_start` pulses once with F6; `pkt_count`=1.
- Held level: `valid_in` held high for 100 cycles → exactly one frame; `pkt_count`=1.
- Back-to-back: three captures 2 cycles apart with `FIFO_DEPTH`=2.
  - First word is popped immediately.
  - Remaining two fill the FIFO.
  - Frames are contiguous: 30 consecutive cycles of `byte_valid`, `pkt_count`=3, `drop_count`=0.
- Overflow: four captures 2 cycles apart → fourth dropped, `ovf_pulse` once, `drop_count`=1, three frames emitted.
- Reset during payload byte 4: `byte_valid`=0 and `byte_out`=00 immediately; counters are 0. A new capture after release yields a clean full frame.
- With `EGRESS_CRC_EN`: payload 64'h0000000000000001 → trailing byte 07, frame is 11 bytes. Payload of all zeros → trailing byte 00.
